// File: rtl/dm_cache_pkg.sv
// rtl/dm_cache_pkg.sv - shared types, defaults and address helpers for the direct-mapped cache
package dm_cache_pkg;

    localparam int DEF_ADDR_W   = 32;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_INDEX_W  = 4;
    localparam int DEF_OFFSET_W = 2;
    localparam int DEF_CNT_W    = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOOKUP   = 3'd1,
        ST_MEM_REQ  = 3'd2,
        ST_MEM_WAIT = 3'd3,
        ST_RESP     = 3'd4
    } dm_state_t;

    // Helpers work on a 64-bit view so any address width up to 64 can share them.
    function automatic logic [63:0] addr_index(input logic [63:0] addr,
                                               input int offset_w,
                                               input int index_w);
        return (addr >> offset_w) & ((64'd1 << index_w) - 64'd1);
    endfunction

    function automatic logic [63:0] addr_tag(input logic [63:0] addr,
                                             input int offset_w,
                                             input int index_w);
        return addr >> (offset_w + index_w);
    endfunction

endpackage

// File: rtl/dm_cache_line_array.sv
// rtl/dm_cache_line_array.sv - valid/tag/data storage with async read, one write port, bulk invalidate
module dm_cache_line_array #(
    parameter int INDEX_W = 4,
    parameter int TAG_W   = 26,
    parameter int DATA_W  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INDEX_W-1:0] rd_idx_i,
    output logic               rd_valid_o,
    output logic [TAG_W-1:0]   rd_tag_o,
    output logic [DATA_W-1:0]  rd_data_o,
    input  logic               wr_en_i,
    input  logic [INDEX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0]   wr_tag_i,
    input  logic [DATA_W-1:0]  wr_data_i,
    input  logic               clear_valid_i
);

    localparam int LINES = 1 << INDEX_W;

    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  valid_d;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES];

    always_comb begin
        valid_d = valid_q;
        if (clear_valid_i) begin
            valid_d = '0;
        end else if (wr_en_i) begin
            valid_d[wr_idx_i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data need no reset: a line is only observed through its valid bit.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/dm_cache_ctrl.sv
// rtl/dm_cache_ctrl.sv - direct-mapped write-through cache controller with CPU/memory handshakes
module dm_cache_ctrl
    import dm_cache_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int INDEX_W  = DEF_INDEX_W,
    parameter int OFFSET_W = DEF_OFFSET_W,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req_valid,
    output logic              cpu_req_ready,
    input  logic              cpu_req_we,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    input  logic [DATA_W-1:0] cpu_req_wdata,
    output logic              cpu_resp_valid,
    output logic [DATA_W-1:0] cpu_resp_rdata,
    output logic              cpu_resp_hit,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_rdata,
    input  logic              flush,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;

    dm_state_t         state_q, state_d;
    logic              req_we_q, req_we_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
    logic              lookup_hit_q, lookup_hit_d;
    logic [DATA_W-1:0] res_rdata_q, res_rdata_d;
    logic              res_hit_q, res_hit_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_hit_q, resp_hit_d;
    logic              mem_req_valid_q, mem_req_valid_d;
    logic              mem_req_we_q, mem_req_we_d;
    logic [ADDR_W-1:0] mem_req_addr_q, mem_req_addr_d;
    logic [DATA_W-1:0] mem_req_wdata_q, mem_req_wdata_d;
    logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

    logic [INDEX_W-1:0] req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic               line_valid;
    logic [TAG_W-1:0]   line_tag;
    logic [DATA_W-1:0]  line_data;
    logic               arr_we;
    logic [DATA_W-1:0]  arr_wdata;
    logic               arr_clear;
    logic               lookup_hit;
    logic               mem_req_done;

    assign req_idx      = INDEX_W'(addr_index(64'(req_addr_q), OFFSET_W, INDEX_W));
    assign req_tag      = TAG_W'(addr_tag(64'(req_addr_q), OFFSET_W, INDEX_W));
    assign lookup_hit   = line_valid && (line_tag == req_tag);
    assign mem_req_done = mem_req_valid_q && mem_req_ready;

    assign cpu_req_ready = (state_q == ST_IDLE) && !flush;

    dm_cache_line_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W),
        .DATA_W  (DATA_W)
    ) u_lines (
        .clk           (clk),
        .rst_n         (rst_n),
        .rd_idx_i      (req_idx),
        .rd_valid_o    (line_valid),
        .rd_tag_o      (line_tag),
        .rd_data_o     (line_data),
        .wr_en_i       (arr_we),
        .wr_idx_i      (req_idx),
        .wr_tag_i      (req_tag),
        .wr_data_i     (arr_wdata),
        .clear_valid_i (arr_clear)
    );

    always_comb begin
        state_d      = state_q;
        req_we_d     = req_we_q;
        req_addr_d   = req_addr_q;
        req_wdata_d  = req_wdata_q;
        lookup_hit_d = lookup_hit_q;
        res_rdata_d  = res_rdata_q;
        res_hit_d    = res_hit_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        arr_we       = 1'b0;
        arr_wdata    = req_wdata_q;
        arr_clear    = 1'b0;

        // Outputs are registered from the current state, so they trail the FSM by one cycle.
        resp_valid_d = (state_q == ST_RESP);
        resp_rdata_d = (state_q == ST_RESP) ? res_rdata_q : '0;
        resp_hit_d   = (state_q == ST_RESP) && res_hit_q;

        mem_req_valid_d = (state_q == ST_MEM_REQ) && !mem_req_done;
        mem_req_we_d    = mem_req_we_q;
        mem_req_addr_d  = mem_req_addr_q;
        mem_req_wdata_d = mem_req_wdata_q;
        if ((state_q == ST_MEM_REQ) && !mem_req_valid_q) begin
            mem_req_we_d    = req_we_q;
            mem_req_addr_d  = {req_addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
            mem_req_wdata_d = req_we_q ? req_wdata_q : '0;
        end

        case (state_q)
            ST_IDLE: begin
                if (flush) begin
                    arr_clear = 1'b1;
                end else if (cpu_req_valid) begin
                    req_we_d    = cpu_req_we;
                    req_addr_d  = cpu_req_addr;
                    req_wdata_d = cpu_req_wdata;
                    state_d     = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                lookup_hit_d = lookup_hit;
                if (lookup_hit) begin
                    if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_W'(1);
                end else begin
                    if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
                end
                if (req_we_q) begin
                    arr_we  = lookup_hit;
                    state_d = ST_MEM_REQ;
                end else if (lookup_hit) begin
                    res_rdata_d = line_data;
                    res_hit_d   = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    state_d = ST_MEM_REQ;
                end
            end
            ST_MEM_REQ: begin
                if (mem_req_done) begin
                    if (req_we_q) begin
                        res_rdata_d = '0;
                        res_hit_d   = lookup_hit_q;
                        state_d     = ST_RESP;
                    end else begin
                        state_d = ST_MEM_WAIT;
                    end
                end
            end
            ST_MEM_WAIT: begin
                if (mem_resp_valid) begin
                    arr_we      = 1'b1;
                    arr_wdata   = mem_resp_rdata;
                    res_rdata_d = mem_resp_rdata;
                    res_hit_d   = 1'b0;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            req_we_q        <= 1'b0;
            req_addr_q      <= '0;
            req_wdata_q     <= '0;
            lookup_hit_q    <= 1'b0;
            res_rdata_q     <= '0;
            res_hit_q       <= 1'b0;
            resp_valid_q    <= 1'b0;
            resp_rdata_q    <= '0;
            resp_hit_q      <= 1'b0;
            mem_req_valid_q <= 1'b0;
            mem_req_we_q    <= 1'b0;
            mem_req_addr_q  <= '0;
            mem_req_wdata_q <= '0;
            hit_cnt_q       <= '0;
            miss_cnt_q      <= '0;
        end else begin
            state_q         <= state_d;
            req_we_q        <= req_we_d;
            req_addr_q      <= req_addr_d;
            req_wdata_q     <= req_wdata_d;
            lookup_hit_q    <= lookup_hit_d;
            res_rdata_q     <= res_rdata_d;
            res_hit_q       <= res_hit_d;
            resp_valid_q    <= resp_valid_d;
            resp_rdata_q    <= resp_rdata_d;
            resp_hit_q      <= resp_hit_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_we_q    <= mem_req_we_d;
            mem_req_addr_q  <= mem_req_addr_d;
            mem_req_wdata_q <= mem_req_wdata_d;
            hit_cnt_q       <= hit_cnt_d;
            miss_cnt_q      <= miss_cnt_d;
        end
    end

    assign cpu_resp_valid = resp_valid_q;
    assign cpu_resp_rdata = resp_rdata_q;
    assign cpu_resp_hit   = resp_hit_q;
    assign mem_req_valid  = mem_req_valid_q;
    assign mem_req_we     = mem_req_we_q;
    assign mem_req_addr   = mem_req_addr_q;
    assign mem_req_wdata  = mem_req_wdata_q;
    assign hit_cnt        = hit_cnt_q;
    assign miss_cnt       = miss_cnt_q;

endmodule
